// File: rtl/bitty_instr_feeder.sv
// Instruction feeder: buffers up to DEPTH 16-bit words, then issues
// them one by one to a core via instr/run and waits for done.
// Ports:
//   clk, rst (async, active-low)
//   load_valid, load_data, load_ready : append words while idle
//   start                             : issue the buffered program
//   instr, run                        : registered word + issue strobe
//   done                              : core completion pulse
//   busy, finished, timeout_err       : status
//   count                             : buffered word count
module bitty_instr_feeder #(
   parameter int DEPTH          = 16,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   load_valid,
   input  logic [15:0]            load_data,
   output logic                   load_ready,
   input  logic                   start,
   output logic [15:0]            instr,
   output logic                   run,
   input  logic                   done,
   output logic                   busy,
   output logic                   finished,
   output logic                   timeout_err,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      FINISH
   } state_t;

   state_t        state;
   state_t        state_nx;
   logic [AW-1:0] rd_ptr;
   logic [7:0]    timer;
   logic [15:0]   mem [DEPTH];

   logic do_load;
   logic ack;
   logic last;
   logic tmo;

   assign busy       = (state != IDLE);
   assign load_ready = (state == IDLE)
                     && (count < CW'(DEPTH))
                     && !start;
   assign do_load    = load_valid && load_ready;

   // run is high in the first WAIT cycle; a done seen
   // alongside it belongs to no issued instruction.
   assign ack  = done && !run;
   assign last = ({1'b0, rd_ptr} == (count - CW'(1)));
   assign tmo  = (timer == 8'(TIMEOUT_CYCLES - 1));

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: begin
            if (start) begin
               if (count != '0) state_nx = ISSUE;
               else             state_nx = FINISH;
            end
         end
         ISSUE: state_nx = WAIT;
         WAIT: begin
            if (ack) begin
               if (last) state_nx = FINISH;
               else      state_nx = ISSUE;
            end else if (tmo) begin
               state_nx = FINISH;
            end
         end
         FINISH:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         count       <= '0;
         rd_ptr      <= '0;
         timer       <= '0;
         instr       <= '0;
         run         <= 1'b0;
         finished    <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         state    <= state_nx;
         run      <= (state == ISSUE);
         finished <= (state == FINISH);
         case (state)
            IDLE: begin
               if (start && (count != '0)) begin
                  timeout_err <= 1'b0;
                  rd_ptr      <= '0;
               end else if (do_load) begin
                  count <= count + CW'(1);
               end
            end
            ISSUE: begin
               instr <= mem[rd_ptr];
               timer <= '0;
            end
            WAIT: begin
               timer <= timer + 8'd1;
               if (ack) begin
                  if (!last) rd_ptr <= rd_ptr + AW'(1);
               end else if (tmo) begin
                  timeout_err <= 1'b1;
               end
            end
            FINISH: begin
               count  <= '0;
               rd_ptr <= '0;
            end
            default: ;
         endcase
      end
   end

   // Buffer storage keeps its contents across reset.
   always_ff @(posedge clk) begin
      if (do_load) mem[count[AW-1:0]] <= load_data;
   end

endmodule

// File: tb/tb_bitty_instr_feeder.sv
// Randomized self-checking bench for bitty_instr_feeder.
// A queue-based program model and a core model drive done.
module tb_bitty_instr_feeder;

   localparam int DEPTH = 8;
   localparam int TO    = 10;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        load_valid = 1'b0;
   logic [15:0] load_data = '0;
   logic        load_ready;
   logic        start = 1'b0;
   logic [15:0] instr;
   logic        run;
   logic        done = 1'b0;
   logic        busy;
   logic        finished;
   logic        timeout_err;
   logic [3:0]  count;

   bitty_instr_feeder #(
      .DEPTH(DEPTH),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk),
      .rst(rst),
      .load_valid(load_valid),
      .load_data(load_data),
      .load_ready(load_ready),
      .start(start),
      .instr(instr),
      .run(run),
      .done(done),
      .busy(busy),
      .finished(finished),
      .timeout_err(timeout_err),
      .count(count)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;

   // program model
   logic [15:0] mbuf [DEPTH];
   int          mcnt = 0;
   bit          mte = 1'b0;
   logic [15:0] exp_q [$];

   // core model / observers
   int core_lat = -1;
   bit stray = 1'b0;
   int cd = 0;
   int run_n = 0;
   int fin_n = 0;
   int first_run_cyc = -1;
   int last_run_cyc = -1;
   int te_cyc = -1;
   int fin_cyc = -1;
   int start_cyc = 0;
   bit prev_te = 1'b0;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] expv);
      n_chk++;
      if (obs !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h",
                  tag, obs, expv);
      end
   endtask

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      logic d;
      logic [15:0] w;
      d = 1'b0;
      if (!rst) begin
         cd = 0;
         prev_te = 1'b0;
      end else begin
         if (run) begin
            run_n++;
            if (last_run_cyc >= 0 && core_lat > 0)
               chk("run_gap", cyc - last_run_cyc, core_lat + 2);
            last_run_cyc = cyc;
            if (first_run_cyc < 0) first_run_cyc = cyc;
            chk("run_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
               w = exp_q.pop_front();
               chk("instr", instr, w);
            end
         end
         if (finished) begin
            fin_n++;
            fin_cyc = cyc;
         end
         if (timeout_err && !prev_te) te_cyc = cyc;
         prev_te = timeout_err;
         if (cd > 0) begin
            cd--;
            if (cd == 0) d = 1'b1;
         end
         if (run && core_lat > 0) cd = core_lat;
         if (run && stray) d = 1'b1;
      end
      done = d;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_word(input logic [15:0] d);
      load_valid = 1'b1;
      load_data  = d;
      start      = 1'b0;
      #1;
      chk("load_ready", load_ready, mcnt < DEPTH);
      tick();
      if (mcnt < DEPTH) begin
         mbuf[mcnt] = d;
         mcnt++;
      end
      load_valid = 1'b0;
      chk("count", count, mcnt);
   endtask

   task automatic run_prog(input int lat, input bit junk);
      bit to;
      int n_exp;
      int f0;
      int r0;
      int b;
      to = (mcnt > 0) && (lat < 0 || lat + 1 > TO);
      n_exp = to ? 1 : mcnt;
      exp_q = {};
      for (int i = 0; i < n_exp; i++) exp_q.push_back(mbuf[i]);
      if (mcnt > 0) mte = to;
      core_lat = lat;
      stray = junk;
      f0 = fin_n;
      r0 = run_n;
      first_run_cyc = -1;
      last_run_cyc = -1;
      te_cyc = -1;
      start = 1'b1;
      start_cyc = cyc;
      tick();
      start = 1'b0;
      b = 0;
      while (fin_n == f0 && b < 5000) begin
         if (junk && busy) begin
            start      = 1'($urandom_range(0, 1));
            load_valid = 1'($urandom_range(0, 1));
            load_data  = 16'($urandom);
         end else begin
            start      = 1'b0;
            load_valid = 1'b0;
         end
         tick();
         b++;
      end
      start = 1'b0;
      load_valid = 1'b0;
      chk("fin_wait", b < 5000, 1);
      repeat (3) tick();
      chk("fin_once", fin_n - f0, 1);
      chk("run_count", run_n - r0, n_exp);
      chk("q_empty", exp_q.size(), 0);
      chk("count_zero", count, 0);
      chk("busy_idle", busy, 0);
      chk("timeout_err", timeout_err, mte);
      if (mcnt == 0)
         chk("empty_fin_lat", fin_cyc - start_cyc, 2);
      else
         chk("first_run_lat", first_run_cyc - start_cyc, 2);
      if (to) begin
         chk("to_lat", te_cyc - first_run_cyc, TO);
         chk("to_fin_lat", fin_cyc - te_cyc, 1);
      end
      if (n_exp > 0) chk("instr_hold", instr, mbuf[n_exp-1]);
      mcnt = 0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected end");
      $fatal(1);
   end

   initial begin
      int n;
      int r0;
      int f0;
      int b;
      tick();
      tick();
      chk("rst_instr", instr, 0);
      chk("rst_run", run, 0);
      chk("rst_busy", busy, 0);
      chk("rst_fin", finished, 0);
      chk("rst_te", timeout_err, 0);
      chk("rst_count", count, 0);
      chk("rst_ready", load_ready, 1);
      rst = 1'b1;

      // basic three-word program
      load_word(16'h1234);
      load_word(16'h5678);
      load_word(16'h9ABC);
      run_prog(3, 1'b0);

      // empty start
      run_prog(2, 1'b0);

      // full buffer plus one dropped word
      for (int i = 0; i < DEPTH; i++) load_word(16'($urandom));
      load_word(16'hDEAD);
      chk("full_count", count, DEPTH);
      run_prog($urandom_range(1, 3), 1'b1);

      // timeout, then a clean program clears the flag
      load_word(16'h1111);
      load_word(16'h2222);
      run_prog(-1, 1'b0);
      load_word(16'h3333);
      run_prog(1, 1'b0);

      // done on the last allowed cycle wins; one later loses
      load_word(16'h4444);
      load_word(16'h5555);
      run_prog(TO - 1, 1'b0);
      load_word(16'h6666);
      load_word(16'h7777);
      run_prog(TO, 1'b0);

      // reset in the middle of WAIT
      load_word(16'hA5A5);
      load_word(16'h5A5A);
      exp_q = {};
      exp_q.push_back(16'hA5A5);
      core_lat = -1;
      stray = 1'b0;
      last_run_cyc = -1;
      r0 = run_n;
      f0 = fin_n;
      start = 1'b1;
      tick();
      start = 1'b0;
      b = 0;
      while (run_n == r0 && b < 50) begin
         tick();
         b++;
      end
      chk("mid_run_seen", run_n - r0, 1);
      repeat (3) tick();
      #2 rst = 1'b0;
      #1;
      chk("arst_busy", busy, 0);
      chk("arst_run", run, 0);
      chk("arst_fin", finished, 0);
      chk("arst_te", timeout_err, 0);
      chk("arst_count", count, 0);
      chk("arst_instr", instr, 0);
      exp_q = {};
      mcnt = 0;
      mte = 1'b0;
      repeat (2) tick();
      rst = 1'b1;
      repeat (TO + 5) tick();
      chk("arst_no_fin", fin_n - f0, 0);
      chk("arst_no_run", run_n - r0, 1);
      load_word(16'hBEEF);
      load_word(16'hCAFE);
      run_prog(2, 1'b0);

      // random programs
      for (int k = 0; k < 6; k++) begin
         n = $urandom_range(1, DEPTH);
         for (int i = 0; i < n; i++) load_word(16'($urandom));
         run_prog($urandom_range(1, TO - 1),
                  1'($urandom_range(0, 1)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
